// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/result bus for adder_arbiter; res_ovf exists only with ADDER_ARB_OVF_EN
interface adder_arbiter_if;
    logic [2:0]  req_valid;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [2:0]  req_grant;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_id;
`ifdef ADDER_ARB_OVF_EN
    logic        res_ovf;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_grant, res_valid, res_data, res_id, res_ovf
    );
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_grant, res_valid, res_data, res_id, res_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_grant, res_valid, res_data, res_id
    );
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_grant, res_valid, res_data, res_id
    );
`endif
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - three-requester round-robin front end to one shared 32-bit adder
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow flag res_ovf.
module adder_arbiter (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);

    logic        slot_free;
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic [1:0]  last_grant;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;

    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic [1:0]  res_id_q;

    // Grant is gated by rst so nothing is granted while reset is held.
    always_comb begin
        slot_free = !res_valid_q || bus.res_ready;
        grant     = 3'b000;
        if (!rst && slot_free) begin
            case (last_grant)
                2'd0: begin
                    if      (bus.req_valid[1]) grant = 3'b010;
                    else if (bus.req_valid[2]) grant = 3'b100;
                    else if (bus.req_valid[0]) grant = 3'b001;
                end
                2'd1: begin
                    if      (bus.req_valid[2]) grant = 3'b100;
                    else if (bus.req_valid[0]) grant = 3'b001;
                    else if (bus.req_valid[1]) grant = 3'b010;
                end
                default: begin
                    if      (bus.req_valid[0]) grant = 3'b001;
                    else if (bus.req_valid[1]) grant = 3'b010;
                    else if (bus.req_valid[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        grant_idx = 2'd0;
        case (grant)
            3'b010:  grant_idx = 2'd1;
            3'b100:  grant_idx = 2'd2;
            default: grant_idx = 2'd0;
        endcase
    end

    always_comb begin
        op_a = bus.req_a[31:0];
        op_b = bus.req_b[31:0];
        case (grant_idx)
            2'd1: begin
                op_a = bus.req_a[63:32];
                op_b = bus.req_b[63:32];
            end
            2'd2: begin
                op_a = bus.req_a[95:64];
                op_b = bus.req_b[95:64];
            end
            default: begin
                op_a = bus.req_a[31:0];
                op_b = bus.req_b[31:0];
            end
        endcase
        sum = op_a + op_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= 32'h0;
            res_id_q    <= 2'd0;
            last_grant  <= 2'd2;
        end else if (|grant) begin
            res_valid_q <= 1'b1;
            res_data_q  <= sum;
            res_id_q    <= grant_idx;
            last_grant  <= grant_idx;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.req_grant = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

`ifdef ADDER_ARB_OVF_EN
    logic ovf;
    logic res_ovf_q;

    // Signed overflow: like-signed operands producing a sum of the other sign.
    assign ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
        end else if (|grant) begin
            res_ovf_q <= ovf;
        end
    end

    assign bus.res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    adder_arbiter_if bus ();

    adder_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    initial begin
        logic [2:0]  exp_grant;
        logic [31:0] exp_sum;
        tests_run    = 0;
        tests_failed = 0;

        rst           = 1'b1;
        bus.req_valid = 3'b111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(bus.res_valid), 64'd0);
        check("rst_data",  64'(bus.res_data),  64'd0);
        check("rst_id",    64'(bus.res_id),    64'd0);
        check("rst_grant", 64'(bus.req_grant), 64'd0);
`ifdef ADDER_ARB_OVF_EN
        check("rst_ovf",   64'(bus.res_ovf),   64'd0);
`endif

        // First request after reset: requester 0 has priority.
        rst           = 1'b0;
        bus.req_valid = 3'b001;
        set_ops(0, 32'd5, 32'd7);
        @(negedge clk);
        check("first_grant", 64'(bus.req_grant), 64'b001);
        tick();
        check("first_valid", 64'(bus.res_valid), 64'd1);
        check("first_data",  64'(bus.res_data),  64'd12);
        check("first_id",    64'(bus.res_id),    64'd0);

        // Grant requester 2 alone so the next search starts at 0.
        bus.req_valid = 3'b100;
        set_ops(2, 32'd1000, 32'd24);
        @(negedge clk);
        check("r2_grant", 64'(bus.req_grant), 64'b100);
        tick();
        check("r2_data", 64'(bus.res_data), 64'd1024);
        check("r2_id",   64'(bus.res_id),   64'd2);

        // All three requesting: strict rotation at full throughput.
        for (int i = 0; i < 3; i++) set_ops(i, 32'(10 * i + 1), 32'(100 + i));
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_grant = 3'b001 << (k % 3);
            exp_sum   = 32'(10 * (k % 3) + 1 + 100 + (k % 3));
            @(negedge clk);
            check($sformatf("rr_grant%0d", k), 64'(bus.req_grant), 64'(exp_grant));
            tick();
            check($sformatf("rr_valid%0d", k), 64'(bus.res_valid), 64'd1);
            check($sformatf("rr_id%0d", k),    64'(bus.res_id),    64'(k % 3));
            check($sformatf("rr_data%0d", k),  64'(bus.res_data),  64'(exp_sum));
        end

        // Lone requester 1 is granted every cycle.
        bus.req_valid = 3'b010;
        for (int k = 0; k < 3; k++) begin
            set_ops(1, 32'(k), 32'h100);
            @(negedge clk);
            check($sformatf("solo_grant%0d", k), 64'(bus.req_grant), 64'b010);
            tick();
            check($sformatf("solo_data%0d", k), 64'(bus.res_data), 64'(32'h100 + k));
        end

        // Back-pressure: result 0x102/id1 pending, request 1 must wait.
        bus.res_ready = 1'b0;
        set_ops(1, 32'h1000, 32'h234);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_grant%0d", k), 64'(bus.req_grant), 64'b000);
            tick();
            check($sformatf("bp_valid%0d", k), 64'(bus.res_valid), 64'd1);
            check($sformatf("bp_data%0d", k),  64'(bus.res_data),  64'h102);
            check($sformatf("bp_id%0d", k),    64'(bus.res_id),    64'd1);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 64'(bus.req_grant), 64'b010);
        tick();
        check("bp_release_data", 64'(bus.res_data), 64'h1234);
        check("bp_release_valid", 64'(bus.res_valid), 64'd1);

        // Wraparound and signed overflow.
        bus.req_valid = 3'b001;
        set_ops(0, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        check("wrap_grant", 64'(bus.req_grant), 64'b001);
        tick();
        check("wrap_data", 64'(bus.res_data), 64'h0);
`ifdef ADDER_ARB_OVF_EN
        check("wrap_ovf", 64'(bus.res_ovf), 64'd0);
`endif
        set_ops(0, 32'h7FFF_FFFF, 32'h1);
        tick();
        check("ovf_data", 64'(bus.res_data), 64'h8000_0000);
`ifdef ADDER_ARB_OVF_EN
        check("ovf_flag", 64'(bus.res_ovf), 64'd1);
`endif

        // Consume with no new request: valid drops, data/id hold.
        bus.req_valid = 3'b000;
        @(negedge clk);
        check("idle_grant", 64'(bus.req_grant), 64'b000);
        tick();
        check("drain_valid", 64'(bus.res_valid), 64'd0);
        check("drain_data",  64'(bus.res_data),  64'h8000_0000);
        check("drain_id",    64'(bus.res_id),    64'd0);

        // Reset while a result is held and everyone is requesting.
        bus.req_valid = 3'b111;
        bus.res_ready = 1'b0;
        set_ops(0, 32'd40, 32'd2);
        @(negedge clk);
        check("pre_rst_grant", 64'(bus.req_grant), 64'b010);
        tick();
        check("pre_rst_valid", 64'(bus.res_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus.res_valid), 64'd0);
        check("async_rst_grant", 64'(bus.req_grant), 64'b000);
        tick();
        rst           = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 64'(bus.req_grant), 64'b001);
        tick();
        check("post_rst_data", 64'(bus.res_data), 64'd42);
        check("post_rst_id",   64'(bus.res_id),   64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: req_valid  input  3  per-requester add request; bit i = requester i.
REQ-004: req_a  input  96  operand A; requester i uses bits [32*i+31:32*i].
REQ-005: req_b  input  96  operand B; same slicing as req_a.
REQ-006: req_grant  output  3  one-hot, combinational; bit i high = requester i's operands are captured at this edge.
REQ-007: res_valid  output  1  result register holds an unconsumed result.
REQ-008: res_ready  input  1  consumer accepts result when res_valid and res_ready are both high.
REQ-009: res_data  output  32  registered sum.
REQ-010: res_id  output  2  index of the requester that owns res_data (0..2).
REQ-011: res_ovf  output  1  signed overflow of res_data; present only when ADDER_ARB_OVF_EN is defined.

Function
REQ-012: One shared 32-bit adder; sum = A + B modulo 2^32, carry-out discarded.
REQ-013: Output stage is a single-entry buffer; "slot free" = !res_valid || res_ready.
REQ-014: When slot free and any req_valid bit is high, exactly one req_grant bit SHALL be asserted in the same cycle; otherwise req_grant = 3'b000.
REQ-015: Round-robin arbitration; search order starts at (last_grant+1) mod 3, wraps 2->0; first valid requester wins.
REQ-016: last_grant updates only on a cycle with a grant; no grant leaves it unchanged.
REQ-017: On a grant edge: res_data <= A_i + B_i, res_id <= i, res_valid <= 1; latency request-to-result = 1 cycle.
REQ-018: Result consumed with no new grant: res_valid <= 0; res_data/res_id hold last value.
REQ-019: Consume and grant in the same cycle: new result loaded, res_valid stays 1 (full throughput, one add per cycle).
REQ-020: res_valid high and res_ready low: no grant; res_data, res_id, res_valid held stable (back-pressure).
REQ-021: A requester holds req_valid and operands until it sees its grant bit; req_valid dropping before grant is legal and simply withdraws the request.
REQ-022: Single active requester is granted every free cycle (no forced idle gap).
REQ-023: req_grant depends only on req_valid, res_valid, res_ready and last_grant; no path from operands.

Reset
REQ-024: While rst high: res_valid = 0, res_data = 32'h0, res_id = 2'd0, req_grant = 3'b000, last_grant = 2'd2 (so requester 0 has first priority).
REQ-025: rst asserted mid-operation discards any held result immediately (asynchronously); no grant until the first edge after rst deasserts.
REQ-026: res_ovf resets to 0 when present.

Configuration
REQ-027: Macro ADDER_ARB_OVF_EN defined: res_ovf port exists, registered with res_data, = (A[31]==B[31]) && (sum[31]!=A[31]).
REQ-028: ADDER_ARB_OVF_EN undefined: no res_ovf port, no overflow logic; all other behaviour identical.

Verification
REQ-029: Reset then req_valid=3'b001, A0=5, B0=7, res_ready=1 -> req_grant=001 same cycle; next cycle res_valid=1, res_data=12, res_id=0.
REQ-030: req_valid=3'b111 held 6 cycles, res_ready=1 -> grant sequence 001,010,100,001,010,100; res_id 0,1,2,0,1,2 one cycle later.
REQ-031: Result pending, res_ready=0 for 3 cycles with req_valid=3'b010 -> req_grant=000, res_data/res_id stable; res_ready=1 -> consume and grant 010 same cycle.
REQ-032: A0=32'hFFFF_FFFF, B0=32'h1 -> res_data=0; A0=32'h7FFF_FFFF, B0=1 -> res_data=32'h8000_0000, res_ovf=1 (with ADDER_ARB_OVF_EN).
REQ-033: rst pulse while res_valid=1 and req_valid=3'b111 -> res_valid falls immediately; after release, first grant is 001.
